// File: rtl/edm_pkg.sv
// Shared EDM gap-monitor definitions: gap classes, detector FSM states and
// sign-magnitude sample field positions.
package edm_pkg;

  // Sign-magnitude sample word layout (scaler output format)
  localparam int unsigned SM_SIGN    = 15;
  localparam int unsigned SM_MAG_MSB = 14;
  localparam int unsigned SM_W       = SM_SIGN + 1;
  localparam int unsigned MAG_W      = SM_MAG_MSB + 1;

  // Gap classification codes as reported on result_type
  localparam int unsigned GAP_W      = 2;
  localparam logic [GAP_W-1:0] GAP_OPEN   = 2'd0;
  localparam logic [GAP_W-1:0] GAP_NORMAL = 2'd1;
  localparam logic [GAP_W-1:0] GAP_ARC    = 2'd2;
  localparam logic [GAP_W-1:0] GAP_SHORT  = 2'd3;

  // Detector FSM states, visible to the host on gap_state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_DISCH  = 2'd2,
    ST_REPORT = 2'd3
  } gap_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst_n, inc (count one), clr (zero), count (current value).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/discharge_state_detector.sv
// Classifies each EDM pulse as OPEN/NORMAL/ARC/SHORT from sign-magnitude
// current/voltage samples, reports one result per pulse with its ignition
// delay, and keeps saturating per-type statistics.
// Ports: clk, rst_n; sample_current/sample_voltage/sample_en (scaler samples);
// pulse_on (generator gate); v_short_th/i_dis_th/td_arc_min (thresholds);
// clr_stats; result_valid/result_type/result_td (per-pulse report);
// cnt_open/cnt_normal/cnt_arc/cnt_short (totals); gap_state (live FSM state).
module discharge_state_detector
  import edm_pkg::*;
#(
  parameter int unsigned TD_W  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SM_W-1:0]   sample_current,
  input  logic [SM_W-1:0]   sample_voltage,
  input  logic              sample_en,
  input  logic              pulse_on,
  input  logic [MAG_W-1:0]  v_short_th,
  input  logic [MAG_W-1:0]  i_dis_th,
  input  logic [TD_W-1:0]   td_arc_min,
  input  logic              clr_stats,
  output logic              result_valid,
  output logic [GAP_W-1:0]  result_type,
  output logic [TD_W-1:0]   result_td,
  output logic [CNT_W-1:0]  cnt_open,
  output logic [CNT_W-1:0]  cnt_normal,
  output logic [CNT_W-1:0]  cnt_arc,
  output logic [CNT_W-1:0]  cnt_short,
  output logic [1:0]        gap_state
);

  gap_state_e        state_q, state_d;
  logic              pulse_on_q;
  logic [TD_W-1:0]   td_cnt_q, td_cnt_d, td_next;
  logic [MAG_W-1:0]  v_th_q, v_th_d, i_th_q, i_th_d;
  logic [TD_W-1:0]   arc_q, arc_d;
  logic [GAP_W-1:0]  pend_type_q, pend_type_d;
  logic [TD_W-1:0]   pend_td_q, pend_td_d;
  logic              valid_d;
  logic [GAP_W-1:0]  type_q, type_d;
  logic [TD_W-1:0]   td_q, td_d;
  logic [3:0]        cnt_inc;
  logic              pulse_start;
  logic [MAG_W-1:0]  i_mag, v_mag;
  logic              sign_unused;

  // Only magnitudes matter; -0 naturally reads as 0
  assign i_mag       = sample_current[SM_MAG_MSB:0];
  assign v_mag       = sample_voltage[SM_MAG_MSB:0];
  assign sign_unused = sample_current[SM_SIGN] ^ sample_voltage[SM_SIGN];

  // pulse_on_q resets high so a gate already high at release is not a start
  assign pulse_start = pulse_on & ~pulse_on_q;
  assign td_next     = (td_cnt_q == '1) ? td_cnt_q : td_cnt_q + TD_W'(1);

  // Next-state, classification and report logic
  always_comb begin
    state_d     = state_q;
    td_cnt_d    = td_cnt_q;
    v_th_d      = v_th_q;
    i_th_d      = i_th_q;
    arc_d       = arc_q;
    pend_type_d = pend_type_q;
    pend_td_d   = pend_td_q;
    valid_d     = 1'b0;
    type_d      = type_q;
    td_d        = td_q;
    cnt_inc     = '0;

    unique case (state_q)
      ST_IDLE, ST_REPORT: begin
        if (pulse_start) begin
          state_d  = ST_DELAY;
          td_cnt_d = '0;
          v_th_d   = v_short_th;
          i_th_d   = i_dis_th;
          arc_d    = td_arc_min;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DELAY: begin
        td_cnt_d = td_next;
        // Breakdown outranks a coincident gate fall; DISCH then reports it
        if (sample_en && (i_mag >= i_th_q)) begin
          state_d   = ST_DISCH;
          pend_td_d = td_next;
          if (v_mag < v_th_q)       pend_type_d = GAP_SHORT;
          else if (td_next < arc_q) pend_type_d = GAP_ARC;
          else                      pend_type_d = GAP_NORMAL;
        end else if (!pulse_on) begin
          state_d          = ST_REPORT;
          valid_d          = 1'b1;
          type_d           = GAP_OPEN;
          td_d             = td_next;
          cnt_inc[GAP_OPEN] = 1'b1;
        end
      end
      ST_DISCH: begin
        if (!pulse_on) begin
          state_d              = ST_REPORT;
          valid_d              = 1'b1;
          type_d               = pend_type_q;
          td_d                 = pend_td_q;
          cnt_inc[pend_type_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pulse_on_q   <= 1'b1;
      td_cnt_q     <= '0;
      v_th_q       <= '0;
      i_th_q       <= '0;
      arc_q        <= '0;
      pend_type_q  <= '0;
      pend_td_q    <= '0;
      result_valid <= 1'b0;
      type_q       <= '0;
      td_q         <= '0;
    end else begin
      state_q      <= state_d;
      pulse_on_q   <= pulse_on;
      td_cnt_q     <= td_cnt_d;
      v_th_q       <= v_th_d;
      i_th_q       <= i_th_d;
      arc_q        <= arc_d;
      pend_type_q  <= pend_type_d;
      pend_td_q    <= pend_td_d;
      result_valid <= valid_d;
      type_q       <= type_d;
      td_q         <= td_d;
    end
  end

  assign result_type = type_q;
  assign result_td   = td_q;
  assign gap_state   = state_q;

  // Per-type statistics
  sat_counter #(.W(CNT_W)) u_cnt_open (
    .clk(clk), .rst_n(rst_n), .inc(cnt_inc[GAP_OPEN]),   .clr(clr_stats), .count(cnt_open));
  sat_counter #(.W(CNT_W)) u_cnt_normal (
    .clk(clk), .rst_n(rst_n), .inc(cnt_inc[GAP_NORMAL]), .clr(clr_stats), .count(cnt_normal));
  sat_counter #(.W(CNT_W)) u_cnt_arc (
    .clk(clk), .rst_n(rst_n), .inc(cnt_inc[GAP_ARC]),    .clr(clr_stats), .count(cnt_arc));
  sat_counter #(.W(CNT_W)) u_cnt_short (
    .clk(clk), .rst_n(rst_n), .inc(cnt_inc[GAP_SHORT]),  .clr(clr_stats), .count(cnt_short));

endmodule

// File: tb/tb_discharge_state_detector.sv
// Bench for discharge_state_detector: a default instance plus a narrow
// instance (TD_W=4, CNT_W=2) to reach td and counter saturation quickly.
module tb_discharge_state_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_current, sample_voltage;
  logic        sample_en, pulse_on, clr_stats;
  logic [14:0] v_short_th, i_dis_th;
  logic [15:0] td_arc_min;
  logic [3:0]  td_arc_min_s;

  logic        result_valid, s_valid;
  logic [1:0]  result_type, s_type, gap_state, s_gap_state;
  logic [15:0] result_td;
  logic [3:0]  s_td;
  logic [15:0] cnt_open, cnt_normal, cnt_arc, cnt_short;
  logic [1:0]  s_open, s_normal, s_arc, s_short;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  discharge_state_detector dut (
    .clk(clk), .rst_n(rst_n),
    .sample_current(sample_current), .sample_voltage(sample_voltage),
    .sample_en(sample_en), .pulse_on(pulse_on),
    .v_short_th(v_short_th), .i_dis_th(i_dis_th), .td_arc_min(td_arc_min),
    .clr_stats(clr_stats),
    .result_valid(result_valid), .result_type(result_type), .result_td(result_td),
    .cnt_open(cnt_open), .cnt_normal(cnt_normal), .cnt_arc(cnt_arc), .cnt_short(cnt_short),
    .gap_state(gap_state));

  discharge_state_detector #(.TD_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .sample_current(sample_current), .sample_voltage(sample_voltage),
    .sample_en(sample_en), .pulse_on(pulse_on),
    .v_short_th(v_short_th), .i_dis_th(i_dis_th), .td_arc_min(td_arc_min_s),
    .clr_stats(clr_stats),
    .result_valid(s_valid), .result_type(s_type), .result_td(s_td),
    .cnt_open(s_open), .cnt_normal(s_normal), .cnt_arc(s_arc), .cnt_short(s_short),
    .gap_state(s_gap_state));

  typedef struct {
    int          len;
    int          bd;
    logic [15:0] i;
    logic [15:0] v;
    logic [1:0]  typ;
    int          td;
  } vec_t;

  typedef struct packed {
    logic [1:0]       typ;
    logic [15:0]      td;
    logic [3:0]       td_s;
    logic [3:0][15:0] cl;
    logic [3:0][1:0]  cs;
  } exp_t;

  exp_t sb[$];
  int   m_l[4];
  int   m_s[4];
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One pulse: rises for edge E, held high for len edges, optional sample at E+bd
  task automatic run_pulse(input int len, input int bd, input logic [15:0] i_w,
                           input logic [15:0] v_w, input logic [1:0] typ, input int td,
                           input int pre, input int tail, input bit clr_rep);
    exp_t e;
    int   c_valid, nv, vidx, gs_bad;
    c_valid = (bd == len) ? len + 1 : len;
    if (clr_rep) begin
      for (int k = 0; k < 4; k++) begin m_l[k] = 0; m_s[k] = 0; end
    end else begin
      if (m_l[typ] < 65535) m_l[typ]++;
      if (m_s[typ] < 3)     m_s[typ]++;
    end
    e.typ  = typ;
    e.td   = 16'(td);
    e.td_s = (td > 15) ? 4'd15 : 4'(td);
    for (int k = 0; k < 4; k++) begin
      e.cl[k] = 16'(m_l[k]);
      e.cs[k] = 2'(m_s[k]);
    end
    sb.push_back(e);
    repeat (pre) begin
      @(negedge clk);
      pulse_on  = 1'b0;
      sample_en = 1'b0;
    end
    nv = 0; vidx = -1; gs_bad = 0;
    for (int c = 0; c < len + tail; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (result_valid) begin nv++; vidx = c - 1; end
        if (typ != 2'd0 && bd < len && (c - 1) >= bd && (c - 1) < len && gap_state != 2'd2)
          gs_bad++;
      end
      pulse_on  = (c < len);
      sample_en = (c == bd) || ((c % 4 == 0) && (c < len));
      sample_current = (c == bd) ? i_w : 16'd0;
      sample_voltage = (c == bd) ? v_w : 16'd80;
      clr_stats = clr_rep && (c == c_valid);
    end
    sample_en = 1'b0;
    clr_stats = 1'b0;
    if (c_valid + 1 <= len + tail - 2) begin
      check("valid_cycle", 32'(vidx), 32'(c_valid));
      check("valid_width", 32'(nv), 32'd1);
    end
    if (typ != 2'd0 && bd < len) check("gap_disch", 32'(gs_bad), 32'd0);
  endtask

  // Scoreboard: compare every report against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (result_valid || s_valid)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: report type %0d td %0d with nothing expected", result_type, result_td);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_valid_s",  32'(s_valid),    32'd1);
        check("sb_type",     32'(result_type), 32'(e.typ));
        check("sb_td",       32'(result_td),   32'(e.td));
        check("sb_type_s",   32'(s_type),      32'(e.typ));
        check("sb_td_s",     32'(s_td),        32'(e.td_s));
        check("sb_cnt_open",   32'(cnt_open),   32'(e.cl[0]));
        check("sb_cnt_normal", 32'(cnt_normal), 32'(e.cl[1]));
        check("sb_cnt_arc",    32'(cnt_arc),    32'(e.cl[2]));
        check("sb_cnt_short",  32'(cnt_short),  32'(e.cl[3]));
        check("sb_s_open",   32'(s_open),   32'(e.cs[0]));
        check("sb_s_normal", 32'(s_normal), 32'(e.cs[1]));
        check("sb_s_arc",    32'(s_arc),    32'(e.cs[2]));
        check("sb_s_short",  32'(s_short),  32'(e.cs[3]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {len, bd, I, V, expected type, expected td}
    vecs[0] = '{100, 0,  16'h0000, 16'd80,   2'd0, 100}; // open
    vecs[1] = '{60,  40, 16'd20,   16'd25,   2'd1, 40};  // normal
    vecs[2] = '{20,  3,  16'h8014, 16'd25,   2'd2, 3};   // arc, negative I
    vecs[3] = '{50,  50, 16'd20,   16'd2,    2'd3, 50};  // short on gate fall
    vecs[4] = '{30,  5,  16'h8000, 16'd25,   2'd0, 30};  // -0 current is no breakdown
    vecs[5] = '{20,  10, 16'd3,    16'd5,    2'd1, 10};  // I==th, V==th, td==arc_min
    vecs[6] = '{15,  9,  16'h8003, 16'h8004, 2'd3, 9};   // negative V below th
    vecs[7] = '{12,  4,  16'd2,    16'd25,   2'd0, 12};  // I just below th
    vecs[8] = '{8,   1,  16'd100,  16'h8019, 2'd2, 1};   // earliest breakdown
    for (int k = 0; k < 4; k++) begin m_l[k] = 0; m_s[k] = 0; end

    rst_n = 1'b0;
    pulse_on = 1'b0; sample_en = 1'b0; clr_stats = 1'b0;
    sample_current = '0; sample_voltage = '0;
    v_short_th = 15'd5; i_dis_th = 15'd3; td_arc_min = 16'd10; td_arc_min_s = 4'd10;
    repeat (3) @(negedge clk);
    check("rst_gap_state", 32'(gap_state),    32'd0);
    check("rst_valid",     32'(result_valid), 32'd0);
    check("rst_type",      32'(result_type),  32'd0);
    check("rst_td",        32'(result_td),    32'd0);
    check("rst_cnt_open",  32'(cnt_open),     32'd0);
    check("rst_cnt_normal",32'(cnt_normal),   32'd0);
    check("rst_cnt_arc",   32'(cnt_arc),      32'd0);
    check("rst_cnt_short", 32'(cnt_short),    32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 9; n++)
      run_pulse(vecs[n].len, vecs[n].bd, vecs[n].i, vecs[n].v, vecs[n].typ, vecs[n].td, 2, 4, 1'b0);

    // Counter saturation on the narrow instance (2 normals already counted)
    run_pulse(20, 12, 16'd20, 16'd25, 2'd1, 12, 2, 4, 1'b0);
    run_pulse(20, 12, 16'd20, 16'd25, 2'd1, 12, 2, 4, 1'b0);
    check("sat_s_normal", 32'(s_normal),   32'd3);
    check("sat_normal",   32'(cnt_normal), 32'd4);
    // Clear on the report-entry edge wins over the increment
    run_pulse(20, 12, 16'd20, 16'd25, 2'd1, 12, 2, 4, 1'b1);
    check("clr_normal",   32'(cnt_normal), 32'd0);
    check("clr_open",     32'(cnt_open),   32'd0);

    // Back-to-back: next pulse starts during REPORT
    run_pulse(10, 0, 16'd0, 16'd80, 2'd0, 10, 2, 1, 1'b0);
    run_pulse(12, 0, 16'd0, 16'd80, 2'd0, 12, 0, 4, 1'b0);

    // Reset mid-DISCH: abort without report, no restart while gate stays high
    repeat (2) begin @(negedge clk); pulse_on = 1'b0; sample_en = 1'b0; end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pulse_on = 1'b1;
      sample_en = (c == 5);
      sample_current = (c == 5) ? 16'd20 : 16'd0;
      sample_voltage = 16'd25;
    end
    @(negedge clk);
    sample_en = 1'b0;
    check("rst_mid_disch", 32'(gap_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_gap",   32'(gap_state),    32'd0);
    check("rst_mid_valid", 32'(result_valid), 32'd0);
    check("rst_mid_type",  32'(result_type),  32'd0);
    check("rst_mid_td",    32'(result_td),    32'd0);
    check("rst_mid_cnts",  32'(cnt_open) + 32'(cnt_normal) + 32'(cnt_arc) + 32'(cnt_short), 32'd0);
    for (int k = 0; k < 4; k++) begin m_l[k] = 0; m_s[k] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int stuck;
      stuck = 0;
      repeat (8) begin
        @(negedge clk);
        if (gap_state != 2'd0 || result_valid) stuck++;
      end
      check("rst_no_restart", 32'(stuck), 32'd0);
    end
    run_pulse(30, 15, 16'd20, 16'd25, 2'd1, 15, 2, 4, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
